riscv_exc_sequencer: RTL and testbench

Sequencer for the core's exception and interrupt entry and exit. It sits between the ID-stage decoder, the external interrupt lines and the pipeline controller. It arbitrates sync exceptions, `eret` and level interrupts, and latches the winning cause. It then drives the CSR file's save, cause and restore strobes in lock-step with the controller's PC-redirect acknowledge.

---
 rtl/riscv_defines.sv | 23 ++
 rtl/riscv_irq_prio_enc.sv | 29 ++
 rtl/riscv_exc_sequencer.sv | 145 ++++++++++++++
 tb/tb_riscv_exc_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_defines.sv
// ---------------------------------------------------------------------------
// riscv_defines
// Shared definitions for the exception/interrupt sequencer:
//   - exception cause codes written into the CSR cause register
//   - handler-select (PC mux) encodings
//   - sequencer state enum
// ---------------------------------------------------------------------------
package riscv_defines;

   localparam logic [5:0] EXC_CAUSE_ILLEGAL = 6'h02;
   localparam logic [5:0] EXC_CAUSE_ECALL   = 6'h0B;

   localparam logic [1:0] EXC_PC_IRQ     = 2'd0;
   localparam logic [1:0] EXC_PC_ILLINSN = 2'd1;
   localparam logic [1:0] EXC_PC_ECALL   = 2'd2;

   typedef enum logic [1:0] {
      EXC_IDLE     = 2'd0,
      EXC_WAIT_ACK = 2'd1,
      EXC_SETTLE   = 2'd2
   } exc_state_e;

endpackage

// File: rtl/riscv_irq_prio_enc.sv
// ---------------------------------------------------------------------------
// riscv_irq_prio_enc
// Combinational priority encoder for the level interrupt lines; the lowest
// set index wins.
// Ports:
//   irq_i   [N_IRQ] : interrupt request lines
//   valid_o         : at least one line is set
//   idx_o   [5]     : index of the lowest set line (0 when none set)
// ---------------------------------------------------------------------------
module riscv_irq_prio_enc #(
   parameter int N_IRQ = 32
) (
   input  logic [N_IRQ-1:0] irq_i,
   output logic             valid_o,
   output logic [4:0]       idx_o
);

   always_comb begin
      valid_o = |irq_i;
      idx_o   = '0;
      // Scan downwards so the last hit, i.e. the lowest index, is kept.
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (irq_i[i]) begin
            idx_o = 5'(i);
         end
      end
   end

endmodule

// File: rtl/riscv_exc_sequencer.sv
// ---------------------------------------------------------------------------
// riscv_exc_sequencer
// Arbitrates synchronous exceptions (illegal, ecall), eret and level
// interrupts, latches the winning cause and sequences the CSR save/restore
// strobes against the controller's PC-redirect acknowledge.
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   irq_i [N_IRQ]              : level interrupt requests
//   irq_enable_i               : mstatus IE
//   insn_valid_i               : ID instruction valid (qualifies the next 3)
//   illegal_insn_i/ecall_insn_i/eret_insn_i : ID instruction class
//   ctrl_ack_i                 : controller redirects the PC this cycle
//   exc_req_o                  : exception entry pending (registered)
//   exc_pc_mux_o [2]           : handler select (registered)
//   exc_cause_o [CAUSE_W]      : latched cause (registered)
//   save_exc_cause_o           : CSR cause write strobe
//   exc_save_if_o/exc_save_id_o: mepc source select strobes
//   exc_restore_o              : mstatus restore strobe (eret)
//   exc_taken_o                : one pulse per exception entry
//   busy_o                     : sequencer not idle
// ---------------------------------------------------------------------------
module riscv_exc_sequencer
   import riscv_defines::*;
#(
   parameter int N_IRQ   = 32,
   parameter int CAUSE_W = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_IRQ-1:0]   irq_i,
   input  logic               irq_enable_i,
   input  logic               insn_valid_i,
   input  logic               illegal_insn_i,
   input  logic               ecall_insn_i,
   input  logic               eret_insn_i,
   input  logic               ctrl_ack_i,
   output logic               exc_req_o,
   output logic [1:0]         exc_pc_mux_o,
   output logic [CAUSE_W-1:0] exc_cause_o,
   output logic               save_exc_cause_o,
   output logic               exc_save_if_o,
   output logic               exc_save_id_o,
   output logic               exc_restore_o,
   output logic               exc_taken_o,
   output logic               busy_o
);

   exc_state_e         state_q, state_d;
   logic [CAUSE_W-1:0] cause_q, cause_d;
   logic [1:0]         mux_q, mux_d;
   logic               is_irq_q, is_irq_d;

   logic               irq_valid;
   logic [4:0]         irq_idx;

   logic               illegal_ev, ecall_ev, eret_ev, irq_ev;

   riscv_irq_prio_enc #(
      .N_IRQ (N_IRQ)
   ) u_prio_enc (
      .irq_i   (irq_i),
      .valid_o (irq_valid),
      .idx_o   (irq_idx)
   );

   assign illegal_ev = insn_valid_i & illegal_insn_i;
   assign ecall_ev   = insn_valid_i & ecall_insn_i;
   assign eret_ev    = insn_valid_i & eret_insn_i;
   assign irq_ev     = irq_enable_i & irq_valid;

   always_comb begin
      state_d          = state_q;
      cause_d          = cause_q;
      mux_d            = mux_q;
      is_irq_d         = is_irq_q;
      save_exc_cause_o = 1'b0;
      exc_save_if_o    = 1'b0;
      exc_save_id_o    = 1'b0;
      exc_restore_o    = 1'b0;
      exc_taken_o      = 1'b0;

      unique case (state_q)
         EXC_IDLE: begin
            if (illegal_ev) begin
               cause_d  = CAUSE_W'(EXC_CAUSE_ILLEGAL);
               mux_d    = EXC_PC_ILLINSN;
               is_irq_d = 1'b0;
               state_d  = EXC_WAIT_ACK;
            end else if (ecall_ev) begin
               cause_d  = CAUSE_W'(EXC_CAUSE_ECALL);
               mux_d    = EXC_PC_ECALL;
               is_irq_d = 1'b0;
               state_d  = EXC_WAIT_ACK;
            end else if (eret_ev) begin
               // Restore is issued immediately; no controller handshake.
               exc_restore_o = 1'b1;
               state_d       = EXC_SETTLE;
            end else if (irq_ev) begin
               cause_d  = CAUSE_W'({1'b1, irq_idx});
               mux_d    = EXC_PC_IRQ;
               is_irq_d = 1'b1;
               state_d  = EXC_WAIT_ACK;
            end
         end
         EXC_WAIT_ACK: begin
            // New events are ignored here; the latched cause is what gets saved.
            if (ctrl_ack_i) begin
               save_exc_cause_o = 1'b1;
               exc_save_if_o    = is_irq_q;
               exc_save_id_o    = ~is_irq_q;
               exc_taken_o      = 1'b1;
               state_d          = EXC_SETTLE;
            end
         end
         EXC_SETTLE: begin
            // One dead cycle so the CSR file's updated IE is seen before the
            // next arbitration.
            state_d = EXC_IDLE;
         end
         default: begin
            state_d = EXC_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= EXC_IDLE;
         cause_q  <= '0;
         mux_q    <= '0;
         is_irq_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cause_q  <= cause_d;
         mux_q    <= mux_d;
         is_irq_q <= is_irq_d;
      end
   end

   assign exc_req_o    = (state_q == EXC_WAIT_ACK);
   assign busy_o       = (state_q != EXC_IDLE);
   assign exc_cause_o  = cause_q;
   assign exc_pc_mux_o = mux_q;

endmodule

// File: tb/tb_riscv_exc_sequencer.sv
module tb_riscv_exc_sequencer;

   localparam int N_IRQ   = 32;
   localparam int CAUSE_W = 6;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [N_IRQ-1:0]   irq_i = '0;
   logic               irq_enable_i = 1'b0;
   logic               insn_valid_i = 1'b0;
   logic               illegal_insn_i = 1'b0;
   logic               ecall_insn_i = 1'b0;
   logic               eret_insn_i = 1'b0;
   logic               ctrl_ack_i = 1'b0;
   logic               exc_req_o;
   logic [1:0]         exc_pc_mux_o;
   logic [CAUSE_W-1:0] exc_cause_o;
   logic               save_exc_cause_o;
   logic               exc_save_if_o;
   logic               exc_save_id_o;
   logic               exc_restore_o;
   logic               exc_taken_o;
   logic               busy_o;

   int checks = 0;
   int failures = 0;

   int save_cnt = 0, if_cnt = 0, id_cnt = 0, rest_cnt = 0, taken_cnt = 0;
   int s0, t0, f0, d0, r0;
   logic seen;

   riscv_exc_sequencer #(.N_IRQ(N_IRQ), .CAUSE_W(CAUSE_W)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .irq_i            (irq_i),
      .irq_enable_i     (irq_enable_i),
      .insn_valid_i     (insn_valid_i),
      .illegal_insn_i   (illegal_insn_i),
      .ecall_insn_i     (ecall_insn_i),
      .eret_insn_i      (eret_insn_i),
      .ctrl_ack_i       (ctrl_ack_i),
      .exc_req_o        (exc_req_o),
      .exc_pc_mux_o     (exc_pc_mux_o),
      .exc_cause_o      (exc_cause_o),
      .save_exc_cause_o (save_exc_cause_o),
      .exc_save_if_o    (exc_save_if_o),
      .exc_save_id_o    (exc_save_id_o),
      .exc_restore_o    (exc_restore_o),
      .exc_taken_o      (exc_taken_o),
      .busy_o           (busy_o)
   );

   always #5 clk = ~clk;

   // Strobes are sampled at the edge that consumes them.
   always @(posedge clk) begin
      if (save_exc_cause_o) save_cnt++;
      if (exc_save_if_o)    if_cnt++;
      if (exc_save_id_o)    id_cnt++;
      if (exc_restore_o)    rest_cnt++;
      if (exc_taken_o)      taken_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic snap();
      s0 = save_cnt; f0 = if_cnt; d0 = id_cnt; r0 = rest_cnt; t0 = taken_cnt;
   endtask

   initial begin
      // ---------------- reset state ----------------
      #2;
      chk("rst_req",   32'(exc_req_o), 0);
      chk("rst_cause", 32'(exc_cause_o), 0);
      chk("rst_mux",   32'(exc_pc_mux_o), 0);
      chk("rst_busy",  32'(busy_o), 0);
      chk("rst_strb",  32'({save_exc_cause_o, exc_save_if_o, exc_save_id_o,
                             exc_restore_o, exc_taken_o}), 0);
      step();
      rst_n = 1'b1;
      step();

      // ---------------- irq 5, ack at T+2 ----------------
      snap();
      irq_enable_i = 1'b1;
      irq_i = 32'h1 << 5;
      chk("irq5_pre_req", 32'(exc_req_o), 0);
      step();
      chk("irq5_req",   32'(exc_req_o), 1);
      chk("irq5_cause", 32'(exc_cause_o), 32'h25);
      chk("irq5_mux",   32'(exc_pc_mux_o), 0);
      chk("irq5_noack_strb", 32'({save_exc_cause_o, exc_taken_o}), 0);
      step();
      chk("irq5_wait_req", 32'(exc_req_o), 1);
      ctrl_ack_i = 1'b1;
      #1;
      chk("irq5_ack_strb", 32'({save_exc_cause_o, exc_save_if_o, exc_save_id_o,
                                 exc_taken_o}), 32'b1101);
      step();
      ctrl_ack_i = 1'b0;
      irq_i = '0;
      chk("irq5_settle_busy", 32'(busy_o), 1);
      chk("irq5_settle_req",  32'(exc_req_o), 0);
      step();
      chk("irq5_idle_busy", 32'(busy_o), 0);
      chk("irq5_save_cnt",  32'(save_cnt - s0), 1);
      chk("irq5_if_cnt",    32'(if_cnt - f0), 1);
      chk("irq5_taken_cnt", 32'(taken_cnt - t0), 1);
      chk("irq5_id_cnt",    32'(id_cnt - d0), 0);

      // ---------------- irq 3 and 7 -> lowest wins ----------------
      irq_i = (32'h1 << 3) | (32'h1 << 7);
      step();
      chk("irq37_cause", 32'(exc_cause_o), 32'h23);
      ctrl_ack_i = 1'b1;
      step();
      ctrl_ack_i = 1'b0;
      irq_i = '0;
      step();

      // ---------------- IE=0 masks interrupts ----------------
      irq_enable_i = 1'b0;
      irq_i = (32'h1 << 3) | (32'h1 << 7);
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (exc_req_o !== 1'b0) seen = 1'b1;
      end
      chk("ie0_no_req", 32'(seen), 0);
      irq_i = '0;

      // ---------------- illegal beats irq[0], then irq entry ----------------
      snap();
      irq_enable_i = 1'b1;
      irq_i = 32'h1;
      insn_valid_i = 1'b1;
      illegal_insn_i = 1'b1;
      step();
      insn_valid_i = 1'b0;
      illegal_insn_i = 1'b0;
      chk("ill_cause", 32'(exc_cause_o), 32'h02);
      chk("ill_mux",   32'(exc_pc_mux_o), 1);
      ctrl_ack_i = 1'b1;
      #1;
      chk("ill_ack_strb", 32'({save_exc_cause_o, exc_save_if_o, exc_save_id_o,
                                exc_taken_o}), 32'b1011);
      step();
      ctrl_ack_i = 1'b0;
      chk("ill_settle_req", 32'(exc_req_o), 0);
      step();
      chk("ill_idle_req", 32'(exc_req_o), 0);
      step();
      chk("irq0_req",   32'(exc_req_o), 1);
      chk("irq0_cause", 32'(exc_cause_o), 32'h20);
      chk("irq0_mux",   32'(exc_pc_mux_o), 0);
      ctrl_ack_i = 1'b1;
      step();
      ctrl_ack_i = 1'b0;
      irq_i = '0;
      step();
      chk("ill_id_cnt", 32'(id_cnt - d0), 1);
      chk("ill_if_cnt", 32'(if_cnt - f0), 1);

      // ---------------- ecall (irq pending, IE=1) ----------------
      irq_i = 32'h1 << 9;
      insn_valid_i = 1'b1;
      ecall_insn_i = 1'b1;
      step();
      insn_valid_i = 1'b0;
      ecall_insn_i = 1'b0;
      irq_i = '0;
      chk("ecall_cause", 32'(exc_cause_o), 32'h0B);
      chk("ecall_mux",   32'(exc_pc_mux_o), 2);
      ctrl_ack_i = 1'b1;
      step();
      ctrl_ack_i = 1'b0;
      step();

      // ---------------- eret ----------------
      snap();
      insn_valid_i = 1'b1;
      eret_insn_i = 1'b1;
      #1;
      chk("eret_restore", 32'(exc_restore_o), 1);
      step();
      insn_valid_i = 1'b0;
      eret_insn_i = 1'b0;
      chk("eret_busy",        32'(busy_o), 1);
      chk("eret_restore_off", 32'(exc_restore_o), 0);
      chk("eret_req",         32'(exc_req_o), 0);
      step();
      chk("eret_idle", 32'(busy_o), 0);
      chk("eret_rest_cnt", 32'(rest_cnt - r0), 1);
      chk("eret_save_cnt", 32'(save_cnt - s0), 0);

      // ---------------- irq drops in WAIT_ACK, ack held 3 cycles ----------------
      snap();
      irq_i = 32'h1 << 2;
      step();
      irq_i = '0;
      step();
      chk("drop_req",   32'(exc_req_o), 1);
      chk("drop_cause", 32'(exc_cause_o), 32'h22);
      ctrl_ack_i = 1'b1;
      step();
      step();
      step();
      ctrl_ack_i = 1'b0;
      chk("drop_save_cnt",  32'(save_cnt - s0), 1);
      chk("drop_taken_cnt", 32'(taken_cnt - t0), 1);
      chk("drop_idle_req",  32'(exc_req_o), 0);

      // ---------------- async reset in WAIT_ACK ----------------
      snap();
      irq_i = 32'h1 << 1;
      step();
      chk("rstw_req_before", 32'(exc_req_o), 1);
      irq_i = '0;
      #2;
      rst_n = 1'b0;
      ctrl_ack_i = 1'b1;
      #1;
      chk("rstw_req",   32'(exc_req_o), 0);
      chk("rstw_busy",  32'(busy_o), 0);
      chk("rstw_cause", 32'(exc_cause_o), 0);
      chk("rstw_mux",   32'(exc_pc_mux_o), 0);
      chk("rstw_strb",  32'({save_exc_cause_o, exc_save_if_o, exc_save_id_o,
                              exc_restore_o, exc_taken_o}), 0);
      step();
      ctrl_ack_i = 1'b0;
      rst_n = 1'b1;
      step();
      step();
      step();
      chk("rstw_save_cnt",  32'(save_cnt - s0), 0);
      chk("rstw_taken_cnt", 32'(taken_cnt - t0), 0);
      chk("rstw_idle",      32'(busy_o), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
